// File: rtl/fir_pkg.sv
// Shared types and sizing for the FIR sequencing controller and its packer.
package fir_pkg;

    localparam int NTAPS  = 11;              // coefficient taps
    localparam int DW     = 8;               // sample / coefficient width
    localparam int PAR    = 3;               // samples per parallel group
    localparam int AW     = 4;               // coefficient address width
    localparam int HW     = NTAPS * DW;      // flattened coefficient bus width
    localparam int GRP_W  = 16;              // group counter width
    localparam int OUT_W  = 5;               // outstanding-group counter width
    localparam int SLOT_W = $clog2(PAR);     // packer slot index width

    localparam logic [AW-1:0]    MAX_ADDR  = AW'(NTAPS - 1);
    localparam logic [NTAPS-1:0] MASK_FULL = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        FIN
    } state_e;

endpackage

// File: rtl/fir_packer.sv
// Collects serial samples into groups of three for the parallel FIR.
// A group is emitted when the third slot fills, or early on a last sample,
// in which case the unfilled slots are zero-padded.
module fir_packer
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          accept,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic [DW-1:0] din_0,
    output logic [DW-1:0] din_1,
    output logic [DW-1:0] din_2,
    output logic          vin,
    output logic          emit
);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DW-1:0]     s0_q, s0_d;
    logic [DW-1:0]     s1_q, s1_d;
    logic [DW-1:0]     din0_q, din0_d;
    logic [DW-1:0]     din1_q, din1_d;
    logic [DW-1:0]     din2_q, din2_d;
    logic              vin_q, vin_d;

    // Next-state for slot fill, group emission and zero padding.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise the
        // paths that do not assign it would infer a latch.
        slot_d = slot_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        din0_d = din0_q;
        din1_d = din1_q;
        din2_d = din2_q;
        emit   = 1'b0;

        if (clr) begin
            slot_d = '0;
            s0_d   = '0;
            s1_d   = '0;
        end else if (accept) begin
            unique case (slot_q)
                SLOT_W'(0): begin
                    if (s_last) begin
                        din0_d = s_data;
                        din1_d = '0;
                        din2_d = '0;
                        emit   = 1'b1;
                    end else begin
                        s0_d   = s_data;
                        slot_d = SLOT_W'(1);
                    end
                end
                SLOT_W'(1): begin
                    if (s_last) begin
                        din0_d = s0_q;
                        din1_d = s_data;
                        din2_d = '0;
                        emit   = 1'b1;
                        slot_d = '0;
                    end else begin
                        s1_d   = s_data;
                        slot_d = SLOT_W'(2);
                    end
                end
                default: begin
                    din0_d = s0_q;
                    din1_d = s1_q;
                    din2_d = s_data;
                    emit   = 1'b1;
                    slot_d = '0;
                end
            endcase
        end

        vin_d = emit;
    end

    // Packer registers; din holds its value between groups.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            slot_q <= '0;
            s0_q   <= '0;
            s1_q   <= '0;
            din0_q <= '0;
            din1_q <= '0;
            din2_q <= '0;
            vin_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            din0_q <= din0_d;
            din1_q <= din1_d;
            din2_q <= din2_d;
            vin_q  <= vin_d;
        end
    end

    assign din_0 = din0_q;
    assign din_1 = din1_q;
    assign din_2 = din2_q;
    assign vin   = vin_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencing controller for a 3-parallel 11-tap FIR: coefficient bank with
// load tracking, run FSM, group counter and outstanding-result tracking.
module fir_seq_ctrl
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [DW-1:0]    cfg_data,
    input  logic             start,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic [DW-1:0]    din_0,
    output logic [DW-1:0]    din_1,
    output logic [DW-1:0]    din_2,
    output logic             vin,
    output logic [HW-1:0]    h_bus,
    input  logic             fir_vout,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [GRP_W-1:0] grp_cnt
);

    state_e             state_q, state_d;
    logic [HW-1:0]      h_q, h_d;
    logic [NTAPS-1:0]   mask_q, mask_d;
    logic               cfg_err_q, cfg_err_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               pk_clr;
    logic               accept;
    logic               emit;
    logic               out_inc;
    logic               out_dec;

    assign accept = s_valid && s_ready;

    fir_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .clr    (pk_clr),
        .accept (accept),
        .s_data (s_data),
        .s_last (s_last),
        .din_0  (din_0),
        .din_1  (din_1),
        .din_2  (din_2),
        .vin    (vin),
        .emit   (emit)
    );

    // Coefficient writes, run FSM, group and outstanding counters.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        mask_d    = mask_q;
        cfg_err_d = 1'b0;
        grp_d     = grp_q;
        out_d     = out_q;
        pk_clr    = 1'b0;

        // Writes are only legal while idle and within the tap range.
        if (cfg_we) begin
            if (state_q == IDLE && cfg_addr <= MAX_ADDR) begin
                h_d[cfg_addr*DW +: DW] = cfg_data;
                mask_d[cfg_addr]       = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        if (emit && grp_q != '1) begin
            grp_d = grp_q + 1'b1;
        end

        // A result with nothing outstanding is spurious and dropped.
        out_inc = vin;
        out_dec = fir_vout && (out_q != '0);
        if (out_inc && !out_dec && out_q != '1) begin
            out_d = out_q + 1'b1;
        end else if (out_dec && !out_inc) begin
            out_d = out_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (mask_q == MASK_FULL) begin
                        state_d = RUN;
                        grp_d   = '0;
                        out_d   = '0;
                        pk_clr  = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept && s_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (out_q == '0 && !vin) begin
                    state_d = FIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        // NOTE: the coefficient bank is reset explicitly because its load mask
        // and bus contents must read as zero after reset, unlike a plain RAM.
        if (rst) begin
            state_q   <= IDLE;
            h_q       <= '0;
            mask_q    <= '0;
            cfg_err_q <= 1'b0;
            grp_q     <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            mask_q    <= mask_d;
            cfg_err_q <= cfg_err_d;
            grp_q     <= grp_d;
            out_q     <= out_d;
        end
    end

    assign s_ready = (state_q == RUN);
    assign busy    = (state_q == RUN) || (state_q == FLUSH);
    assign done    = (state_q == FIN);
    assign cfg_err = cfg_err_q;
    assign h_bus   = h_q;
    assign grp_cnt = grp_q;

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 CLK  in  1  system clock; all state changes on rising edge.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 CFG_WE  in  1  coefficient write strobe.
REQ-005 CFG_ADDR  in  4  coefficient index 0..10.
REQ-006 CFG_DATA  in  8  coefficient value, signed two's complement.
REQ-007 START  in  1  one-cycle pulse that begins a filtering run.
REQ-008 S_VALID / S_DATA / S_LAST  in  1/8/1  serial sample stream; S_LAST marks the final sample.
REQ-009 S_READY  out  1  sample accepted when S_VALID & S_READY.
REQ-010 DIN_0 / DIN_1 / DIN_2  out  8 each  packed samples to the 3-parallel FIR; DIN_0 is the oldest.
REQ-011 VIN  out  1  one-cycle valid strobe for the DIN group.
REQ-012 H_BUS  out  88  coefficients; H0 at [7:0] through H10 at [87:80].
REQ-013 FIR_VOUT  in  1  FIR output-valid, one pulse per completed group.
REQ-014 BUSY / DONE / CFG_ERR  out  1 each  run active / one-cycle run-complete pulse / one-cycle config-error pulse.
REQ-015 GRP_CNT  out  16  groups issued in the current or last run.

Function
REQ-016 FSM states are IDLE, RUN, FLUSH, and FIN.
REQ-017 In IDLE, a CFG_WE with CFG_ADDR<=10 writes H_BUS slot CFG_ADDR and sets bit CFG_ADDR of an 11-bit loaded mask on the next edge.
REQ-018 CFG_WE with CFG_ADDR>10 in any state, or CFG_WE in any state other than IDLE, leaves H_BUS unchanged and pulses CFG_ERR the next cycle.
REQ-019 In IDLE, START with loaded mask = all ones moves to RUN, clears GRP_CNT, the outstanding counter, and the packer.
REQ-020 In IDLE, START with an incomplete mask stays in IDLE and pulses CFG_ERR.
REQ-021 S_READY=1 only in RUN.
REQ-022 Accepted samples fill packer slots 0, 1, 2 in order.
REQ-023 On the cycle the third slot fills, DIN_0..2 and VIN=1 are registered, so VIN appears 1 cycle after the third acceptance; GRP_CNT increments with it.
REQ-024 DIN_0..2 hold their last values while VIN=0.
REQ-025 S_LAST accepted in slot 0 or 1 zero-pads the remaining slots and emits the group per REQ-023.
REQ-026 S_LAST accepted in slot 2 emits normally.
REQ-027 After S_LAST is accepted, the FSM moves to FLUSH.
REQ-028 The outstanding counter (5-bit) increments on VIN and decrements on FIR_VOUT; if both occur in the same cycle, it is unchanged.
REQ-029 FIR_VOUT with outstanding=0 is ignored (no underflow).
REQ-030 FLUSH moves to FIN when outstanding=0 and VIN=0.
REQ-031 FIN pulses DONE for one cycle and then returns to IDLE.
REQ-032 BUSY=1 in RUN and FLUSH.
REQ-033 GRP_CNT saturates at 16'hFFFF.
REQ-034 START outside IDLE is ignored.
REQ-035 The loaded mask and H_BUS persist across runs.

Reset
REQ-036 RST forces IDLE on the next edge, including mid-run.
REQ-037 After RST, H_BUS=0, loaded mask=0, DIN_0..2=0, and VIN, S_READY, BUSY, DONE, CFG_ERR=0.
REQ-038 After RST, GRP_CNT=0, outstanding=0, and the packer is empty.
REQ-039 RST has priority over every other input.

Structure
REQ-040 Shared package fir_pkg SHALL hold: the state enum, NTAPS=11, DW=8, PAR=3, and widths for GRP_CNT and the outstanding counter.
REQ-041 One sub-module, fir_packer, SHALL contain the 3-slot packer with zero-pad on last.
REQ-042 The FSM, coefficient bank, and counters stay in fir_seq_ctrl.

Verification
REQ-043 Load: write H0..H10 = 1..11, then START → H_BUS[7:0]=1, H_BUS[87:80]=11, BUSY=1 next cycle, CFG_ERR=0.
REQ-044 Incomplete config: write H0..H9 only, then START → CFG_ERR pulse, BUSY stays 0. Also CFG_ADDR=12 → CFG_ERR pulse, H_BUS unchanged.
REQ-045 Packing: samples 5, 6, 7, 8, then S_LAST with 9 → group (5,6,7) with VIN 1 cycle after 7; group (8,9,0); GRP_CNT=2; FLUSH entered.
REQ-046 Drain: two FIR_VOUT pulses, one coincident with the second VIN → outstanding ends at 0, DONE pulses once, then IDLE.
REQ-047 Mid-run reset: assert RST after 4 samples → all outputs at reset values next cycle; a new START after reloading coefficients packs from slot 0.
REQ-048 Config write during RUN → CFG_ERR pulse, H_BUS unchanged.
